// File: rtl/vec_modexp_unit.sv
// vec_modexp_unit
//    Multi-cycle vector modular exponentiation execute stage. For every lane i
//    it computes wb_data[i] = in_vec[i] ^ in_exp mod in_mod with right-to-left
//    square-and-multiply, one exponent bit per RUN cycle. The result goes
//    straight to the register-file write port.
//
// Ports
//    clk, rst   clock (rising edge), asynchronous active-high reset
//    in_valid   issue stage presents a job
//    in_ready   unit idle and able to accept a job
//    in_vec     base vector, LANES x LANE_W
//    in_exp     exponent shared by all lanes
//    in_mod     modulus N shared by all lanes
//    in_rd      destination register index
//    wb_we      one-cycle write strobe (regfile WE3)
//    wb_addr    destination index (regfile A3), holds until the next write
//    wb_data    result vector (regfile WD3), holds until the next write
//    busy       job in flight
//    err_mod0   sticky flag: the last accepted job had N == 0
//
// state | meaning
// IDLE  | waiting for in_valid, in_ready = 1
// LOAD  | reduce base and seed result with 1 mod N
// RUN   | one square-and-multiply step per cycle, exponent shifts right
// DONE  | write strobe cycle, result on wb_data

module vec_modexp_unit #(
   parameter int LANES     = 6,
   parameter int LANE_W    = 8,
   parameter int EXP_W     = 8,
   parameter int REG_IDX_W = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [LANES-1:0][LANE_W-1:0]      in_vec,
   input  logic [EXP_W-1:0]                  in_exp,
   input  logic [LANE_W-1:0]                 in_mod,
   input  logic [REG_IDX_W-1:0]              in_rd,
   output logic                              wb_we,
   output logic [REG_IDX_W-1:0]              wb_addr,
   output logic [LANES-1:0][LANE_W-1:0]      wb_data,
   output logic                              busy,
   output logic                              err_mod0
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t                         state_q, state_d;
   logic [LANES-1:0][LANE_W-1:0]   vec_q;
   logic [LANES-1:0][LANE_W-1:0]   base_q, base_d;
   logic [LANES-1:0][LANE_W-1:0]   res_q, res_d;
   logic [EXP_W-1:0]               exp_q, exp_d;
   logic [LANE_W-1:0]              mod_q;
   logic [REG_IDX_W-1:0]           rd_q;
   logic                           accept;

   // (a*b) mod n on a full double-width product; n == 0 yields 0 by definition.
   function automatic logic [LANE_W-1:0] mulmod(input logic [LANE_W-1:0] a,
                                                input logic [LANE_W-1:0] b,
                                                input logic [LANE_W-1:0] n);
      logic [2*LANE_W-1:0] prod;
      logic [2*LANE_W-1:0] rem;
      prod = {{LANE_W{1'b0}}, a} * {{LANE_W{1'b0}}, b};
      rem  = '0;
      if (n != '0) begin
         rem = prod % {{LANE_W{1'b0}}, n};
      end
      return rem[LANE_W-1:0];
   endfunction

   assign in_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      res_d   = res_q;
      exp_d   = exp_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            for (int i = 0; i < LANES; i++) begin
               base_d[i] = mulmod(vec_q[i], LANE_W'(1), mod_q);
               res_d[i]  = mulmod(LANE_W'(1), LANE_W'(1), mod_q);
            end
            state_d = (exp_q == '0) ? DONE : RUN;
         end
         RUN: begin
            // Both updates read the old base so the square lands one step later.
            for (int i = 0; i < LANES; i++) begin
               if (exp_q[0]) begin
                  res_d[i] = mulmod(res_q[i], base_q[i], mod_q);
               end
               base_d[i] = mulmod(base_q[i], base_q[i], mod_q);
            end
            exp_d = exp_q >> 1;
            if (exp_d == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         vec_q    <= '0;
         base_q   <= '0;
         res_q    <= '0;
         exp_q    <= '0;
         mod_q    <= '0;
         rd_q     <= '0;
         err_mod0 <= 1'b0;
         wb_we    <= 1'b0;
         wb_addr  <= '0;
         wb_data  <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         res_q   <= res_d;
         if (accept) begin
            vec_q    <= in_vec;
            exp_q    <= in_exp;
            mod_q    <= in_mod;
            rd_q     <= in_rd;
            err_mod0 <= (in_mod == '0);
         end else begin
            exp_q <= exp_d;
         end
         // Outputs are registered on entry to DONE so the strobe is aligned
         // with the DONE cycle and the data/address persist afterwards.
         wb_we <= (state_d == DONE);
         if (state_d == DONE) begin
            wb_addr <= rd_q;
            wb_data <= res_d;
         end
      end
   end

endmodule

// File: tb/tb_vec_modexp_unit.sv
module tb_vec_modexp_unit;

   localparam int LANES     = 6;
   localparam int LANE_W    = 8;
   localparam int EXP_W     = 8;
   localparam int REG_IDX_W = 4;

   typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   vec_t                  in_vec = '0;
   logic [EXP_W-1:0]      in_exp = '0;
   logic [LANE_W-1:0]     in_mod = '0;
   logic [REG_IDX_W-1:0]  in_rd = '0;
   logic                  wb_we;
   logic [REG_IDX_W-1:0]  wb_addr;
   vec_t                  wb_data;
   logic                  busy;
   logic                  err_mod0;

   int n_tests = 0;
   int n_fail  = 0;

   vec_modexp_unit #(
      .LANES(LANES), .LANE_W(LANE_W), .EXP_W(EXP_W), .REG_IDX_W(REG_IDX_W)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_vec(in_vec), .in_exp(in_exp), .in_mod(in_mod), .in_rd(in_rd),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .busy(busy), .err_mod0(err_mod0)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_tests++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference: plain repeated multiplication, b^e mod n, with n==0 giving 0.
   function automatic int ref_pow(input int b, input int e, input int n);
      int r;
      if (n == 0) return 0;
      r = 1 % n;
      for (int i = 0; i < e; i++) r = (r * b) % n;
      return r;
   endfunction

   function automatic int ref_k(input int e);
      int k = 0;
      while (e > 0) begin
         e = e / 2;
         k++;
      end
      return k;
   endfunction

   function automatic vec_t ref_vec(input vec_t v, input int e, input int n);
      vec_t r;
      for (int i = 0; i < LANES; i++) r[i] = LANE_W'(ref_pow(int'(v[i]), e, n));
      return r;
   endfunction

   function automatic vec_t rand_vec();
      vec_t r;
      for (int i = 0; i < LANES; i++) r[i] = LANE_W'($urandom);
      return r;
   endfunction

   // Called at a negedge; presents the job and returns just after the accept edge.
   task automatic issue(input vec_t v, input int e, input int n, input int rd, output int waits);
      in_vec   = v;
      in_exp   = EXP_W'(e);
      in_mod   = LANE_W'(n);
      in_rd    = REG_IDX_W'(rd);
      in_valid = 1'b1;
      waits    = 0;
      while (!in_ready && waits < 50) begin
         @(negedge clk);
         waits++;
      end
      if (!in_ready) check("accept_timeout", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
   endtask

   task automatic scramble();
      in_valid = 1'b0;
      in_vec   = rand_vec();
      in_exp   = EXP_W'($urandom);
      in_mod   = LANE_W'($urandom);
      in_rd    = REG_IDX_W'($urandom);
   endtask

   // Follows a job from just after its accept edge to the cycle after DONE.
   task automatic wait_done(input vec_t v, input int e, input int n, input int rd);
      int   lat = 0;
      int   ready_hi = 0;
      vec_t expv;
      expv = ref_vec(v, e, n);
      for (int c = 1; c <= 300 && lat == 0; c++) begin
         @(negedge clk);
         if (wb_we) lat = c;
         else if (in_ready || !busy) ready_hi++;
      end
      check("latency", 64'(lat), 64'(ref_k(e) + 2));
      check("ready_low_in_flight", 64'(ready_hi), 64'(0));
      check("wb_data", 64'(wb_data), 64'(expv));
      check("wb_addr", 64'(wb_addr), 64'(rd));
      check("err_mod0", 64'(err_mod0), 64'(n == 0));
      @(negedge clk);
      check("we_one_cycle", 64'(wb_we), 64'(0));
      check("ready_after_done", 64'(in_ready), 64'(1));
      check("wb_data_hold", 64'(wb_data), 64'(expv));
   endtask

   task automatic job(input vec_t v, input int e, input int n, input int rd);
      int w;
      issue(v, e, n, rd, w);
      scramble();
      wait_done(v, e, n, rd);
   endtask

   initial begin
      vec_t v, v2;
      int   w, seen;

      #12;
      check("rst_ready", 64'(in_ready), 64'(1));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_we", 64'(wb_we), 64'(0));
      check("rst_data", 64'(wb_data), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Directed example with known answer [8,5,9,4,7,2].
      v = {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2};
      job(v, 3, 11, 5);
      check("ex1_lane_values", 64'(wb_data), 64'({8'd2, 8'd7, 8'd4, 8'd9, 8'd5, 8'd8}));

      v = rand_vec();
      v[0] = 8'd2;
      job(v, 17, 33, 3);
      check("ex2_lane0", 64'(wb_data[0]), 64'(29));

      job(rand_vec(), 0, 11, 1);
      job(rand_vec(), 0, 1, 2);
      job(rand_vec(), 5, 0, 4);
      job(rand_vec(), 9, 7, 6);
      job(rand_vec(), 255, 251, 15);
      job(rand_vec(), 200, 1, 7);

      // Randomized jobs, biased toward the small-modulus corner cases.
      for (int t = 0; t < 40; t++) begin
         int n;
         case ($urandom_range(0, 5))
            0:       n = 0;
            1:       n = 1;
            default: n = $urandom_range(2, 255);
         endcase
         job(rand_vec(), $urandom_range(0, 255), n, $urandom_range(0, 15));
      end

      // Back-to-back with in_valid held: second job must wait for in_ready.
      v  = rand_vec();
      v2 = rand_vec();
      @(negedge clk);
      issue(v, 6, 13, 10, w);
      in_vec = v2; in_exp = 8'd11; in_mod = 8'd97; in_rd = 4'd12; in_valid = 1'b1;
      wait_done(v, 6, 13, 10);
      issue(v2, 11, 97, 12, w);
      check("b2b_no_extra_wait", 64'(w), 64'(0));
      scramble();
      wait_done(v2, 11, 97, 12);

      // Reset in the middle of a long job: no write, async return to reset values.
      job(rand_vec(), 4, 0, 9);
      issue(rand_vec(), 255, 0, 8, w);
      scramble();
      repeat (4) @(negedge clk);
      check("pre_rst_busy", 64'(busy), 64'(1));
      rst = 1'b1;
      #1;
      check("arst_ready", 64'(in_ready), 64'(1));
      check("arst_busy", 64'(busy), 64'(0));
      check("arst_addr", 64'(wb_addr), 64'(0));
      check("arst_err", 64'(err_mod0), 64'(0));
      check("arst_data", 64'(wb_data), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (wb_we) seen++;
      end
      check("no_we_after_rst", 64'(seen), 64'(0));
      check("ready_after_rst", 64'(in_ready), 64'(1));

      job(rand_vec(), 13, 7, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
